// File: rtl/decode_pipe_if.sv
// decode_pipe_if: handshake and decoded-field bundle for decode_pipe.
//   slave  modport: the decode stage (takes instructions, drives decoded results)
//   master modport: the surrounding pipeline (fetch side + register-read side)
// Signals:
//   flush                         synchronous FIFO clear (pipeline redirect)
//   in_valid/in_instr/in_ready    instruction input handshake
//   out_valid/out_ready           decoded-entry output handshake
//   op, rs, rt, rd, shamt, funct  raw instruction fields of the head entry
//   ext_imm, target, wr_reg       extended immediate, jump target, destination reg
//   reg_write ... illegal         control lines
//   decoded_cnt, illegal_cnt      statistics, present only with DECODE_STATS_EN
interface decode_pipe_if #(
  parameter int unsigned DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] ext_imm;
  logic [25:0]       target;
  logic [4:0]        wr_reg;
  logic              reg_write;
  logic              alu_src;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic              illegal;
`ifdef DECODE_STATS_EN
  logic [31:0]       decoded_cnt;
  logic [31:0]       illegal_cnt;
`endif

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, op, funct, rs, rt, rd, shamt, ext_imm, target, wr_reg,
    output reg_write, alu_src, mem_read, mem_write, branch, jump, illegal
`ifdef DECODE_STATS_EN
    , output decoded_cnt, illegal_cnt
`endif
  );

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, op, funct, rs, rt, rd, shamt, ext_imm, target, wr_reg,
    input  reg_write, alu_src, mem_read, mem_write, branch, jump, illegal
`ifdef DECODE_STATS_EN
    , input decoded_cnt, illegal_cnt
`endif
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: pipelined MIPS instruction decode stage with a DEPTH-entry output FIFO.
// Instructions are decoded combinationally on acceptance and the decoded record is
// written into the FIFO tail on the same edge; the head record drives the outputs.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (clears pointers, storage, counters)
//   bus    decode_pipe_if.slave (handshakes, flush, decoded fields, control lines)
// Parameters:
//   DATA_W  width of ext_imm (>= 16)
//   DEPTH   FIFO entries (power of two, >= 2)
// Optional feature: define DECODE_STATS_EN to add decoded_cnt / illegal_cnt counters.
module decode_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input logic           clk,
  input logic           reset,
  decode_pipe_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  // Raw fields are recovered from the stored instruction word at the head.
  typedef struct packed {
    logic [31:0]       instr;
    logic [DATA_W-1:0] ext_imm;
    logic [4:0]        wr_reg;
    logic              reg_write;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } entry_t;

  entry_t            dec;
  entry_t            head;
  entry_t            last_q;
  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [5:0]        op_in;
  logic [5:0]        funct_in;
  logic [4:0]        rt_in;
  logic [4:0]        rd_in;
  logic [15:0]       imm;
  logic [DATA_W+15:0] lui_full;
`ifdef DECODE_STATS_EN
  logic [31:0]       decoded_cnt_q;
  logic [31:0]       illegal_cnt_q;
`endif

  assign op_in    = bus.in_instr[31:26];
  assign funct_in = bus.in_instr[5:0];
  assign rt_in    = bus.in_instr[20:16];
  assign rd_in    = bus.in_instr[15:11];
  assign imm      = bus.in_instr[15:0];
  // Wide enough that the shifted immediate never loses bits before truncation to DATA_W.
  assign lui_full = (DATA_W+16)'({imm, 16'h0000});

  always_comb begin
    dec       = '0;
    dec.instr = bus.in_instr;
    case (op_in)
      6'h00: begin
        case (funct_in)
          6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00: begin
            dec.reg_write = 1'b1;
            dec.wr_reg    = rd_in;
          end
          6'h08:        dec.jump    = 1'b1;
          6'h0c, 6'h0d: dec.illegal = 1'b0;  // syscall/break: no controls
          default:      dec.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wr_reg    = rt_in;
      end
      6'h23: begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wr_reg    = rt_in;
      end
      6'h2b: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      6'h04, 6'h05, 6'h07: dec.branch = 1'b1;
      6'h02:               dec.jump   = 1'b1;
      6'h03: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.wr_reg    = 5'd31;
      end
      default:             dec.illegal = 1'b1;
    endcase

    case (op_in)
      6'h0c, 6'h0d: dec.ext_imm = DATA_W'(imm);
      6'h0f:        dec.ext_imm = lui_full[DATA_W-1:0];
      default:      dec.ext_imm = DATA_W'($signed(imm));
    endcase
  end

  assign full         = (count_q == (AW+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign bus.in_ready = !full && !reset;
  assign bus.out_valid = !empty;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
`ifdef DECODE_STATS_EN
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
`endif
    end else begin
`ifdef DECODE_STATS_EN
      // Statistics follow the handshake, independent of any flush.
      if (push) begin
        decoded_cnt_q <= decoded_cnt_q + 32'd1;
        if (dec.illegal) begin
          illegal_cnt_q <= illegal_cnt_q + 32'd1;
        end
      end
`endif
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= dec;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          last_q   <= mem_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + (AW+1)'(1);
          2'b01:   count_q <= count_q - (AW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // When empty the outputs keep showing the most recently consumed entry.
  assign head = empty ? last_q : mem_q[rd_ptr_q];

  assign bus.op        = head.instr[31:26];
  assign bus.rs        = head.instr[25:21];
  assign bus.rt        = head.instr[20:16];
  assign bus.rd        = head.instr[15:11];
  assign bus.shamt     = head.instr[10:6];
  assign bus.funct     = head.instr[5:0];
  assign bus.target    = head.instr[25:0];
  assign bus.ext_imm   = head.ext_imm;
  assign bus.wr_reg    = head.wr_reg;
  assign bus.reg_write = head.reg_write;
  assign bus.alu_src   = head.alu_src;
  assign bus.mem_read  = head.mem_read;
  assign bus.mem_write = head.mem_write;
  assign bus.branch    = head.branch;
  assign bus.jump      = head.jump;
  assign bus.illegal   = head.illegal;
`ifdef DECODE_STATS_EN
  assign bus.decoded_cnt = decoded_cnt_q;
  assign bus.illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: table-driven, scoreboarded bench for decode_pipe (DATA_W=32, DEPTH=2).
module tb_decode_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] ext;
    logic [25:0] target;
    logic [4:0]  wr;
    logic [6:0]  ctrl;  // reg_write, alu_src, mem_read, mem_write, branch, jump, illegal
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [14];
  vec_t sb [$];
  vec_t cur;
  logic [101:0] act;

  decode_pipe_if #(.DATA_W(DATA_W)) bus ();

  decode_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign act = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.ext_imm, bus.target,
                bus.wr_reg, bus.reg_write, bus.alu_src, bus.mem_read, bus.mem_write, bus.branch,
                bus.jump, bus.illegal};

  function automatic logic [101:0] pack_exp(vec_t v);
    return {v.op, v.rs, v.rt, v.rd, v.shamt, v.funct, v.ext, v.target, v.wr, v.ctrl};
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: compare any popped head against the scoreboard, record any accept, advance.
  task automatic step();
    vec_t e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h expected no output", act);
      end else begin
        e = sb.pop_front();
        chk($sformatf("out_%08h", e.instr), 128'(act), 128'(pack_exp(e)));
      end
    end
    if (bus.in_valid && bus.in_ready && !bus.flush && !reset) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v);
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    cur          = v;
  endtask

  task automatic drain(string name);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    step();  // one extra cycle: nothing further may emerge
    chk(name, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{32'h3c011001, 6'h0f, 5'd0,  5'd1,  5'd2,  5'd0,  6'h01, 32'h10010000, 26'h0011001, 5'd1,  7'b1100000};
    tbl[1]  = '{32'h21a9fffe, 6'h08, 5'd13, 5'd9,  5'd31, 5'd31, 6'h3e, 32'hfffffffe, 26'h1a9fffe, 5'd9,  7'b1100000};
    tbl[2]  = '{32'h016c5020, 6'h00, 5'd11, 5'd12, 5'd10, 5'd0,  6'h20, 32'h00005020, 26'h16c5020, 5'd10, 7'b1000000};
    tbl[3]  = '{32'h0c100010, 6'h03, 5'd0,  5'd16, 5'd0,  5'd0,  6'h10, 32'h00000010, 26'h0100010, 5'd31, 7'b1000010};
    tbl[4]  = '{32'h46241000, 6'h11, 5'd17, 5'd4,  5'd2,  5'd0,  6'h00, 32'h00001000, 26'h2241000, 5'd0,  7'b0000001};
    tbl[5]  = '{32'h8c080004, 6'h23, 5'd0,  5'd8,  5'd0,  5'd0,  6'h04, 32'h00000004, 26'h0080004, 5'd8,  7'b1110000};
    tbl[6]  = '{32'hac09fff0, 6'h2b, 5'd0,  5'd9,  5'd31, 5'd31, 6'h30, 32'hfffffff0, 26'h009fff0, 5'd0,  7'b0101000};
    tbl[7]  = '{32'h3082ffff, 6'h0c, 5'd4,  5'd2,  5'd31, 5'd31, 6'h3f, 32'h0000ffff, 26'h082ffff, 5'd2,  7'b1100000};
    tbl[8]  = '{32'h1109fffc, 6'h04, 5'd8,  5'd9,  5'd31, 5'd31, 6'h3c, 32'hfffffffc, 26'h109fffc, 5'd0,  7'b0000100};
    tbl[9]  = '{32'h03e00008, 6'h00, 5'd31, 5'd0,  5'd0,  5'd0,  6'h08, 32'h00000008, 26'h3e00008, 5'd0,  7'b0000010};
    tbl[10] = '{32'h0000000c, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h0c, 32'h0000000c, 26'h000000c, 5'd0,  7'b0000000};
    tbl[11] = '{32'h00000018, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h18, 32'h00000018, 26'h0000018, 5'd0,  7'b0000001};
    tbl[12] = '{32'h00021080, 6'h00, 5'd0,  5'd2,  5'd2,  5'd2,  6'h00, 32'h00001080, 26'h0021080, 5'd2,  7'b1000000};
    tbl[13] = '{32'h08000040, 6'h02, 5'd0,  5'd0,  5'd0,  5'd1,  6'h00, 32'h00000040, 26'h0000040, 5'd0,  7'b0000010};

    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("reset_payload", 128'(act), 128'(0));
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", 128'(bus.in_ready), 128'(1'b1));

    // First accept: visible in the following cycle.
    bus.out_ready = 1'b1;
    drive(tbl[0]);
    step();
    bus.in_valid = 1'b0;
    chk("latency_out_valid", 128'(bus.out_valid), 128'(1'b1));
    drain("drain_first");

    // Full table at one instruction per cycle.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("stream_in_ready_%0d", i), 128'(bus.in_ready), 128'(1'b1));
    end
    drain("drain_table");

    // Back-pressure: fill, stall, then release.
    bus.out_ready = 1'b0;
    drive(tbl[5]);
    step();
    drive(tbl[6]);
    step();
    drive(tbl[7]);
    chk("full_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("full_out_valid", 128'(bus.out_valid), 128'(1'b1));
    step();
    chk("full_hold_in_ready", 128'(bus.in_ready), 128'(1'b0));
    bus.out_ready = 1'b1;
    step();
    chk("reassert_in_ready", 128'(bus.in_ready), 128'(1'b1));
    step();
    drain("drain_backpressure");

    // Flush on a full FIFO, then flush with a push that would otherwise be accepted.
    bus.out_ready = 1'b0;
    drive(tbl[8]);
    step();
    drive(tbl[9]);
    step();
    drive(tbl[10]);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_full_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("flush_full_in_ready", 128'(bus.in_ready), 128'(1'b1));
    drive(tbl[11]);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_push_out_valid", 128'(bus.out_valid), 128'(1'b0));
    sb.delete();
    bus.out_ready = 1'b1;
    drive(tbl[12]);
    step();
    drain("drain_after_flush");

    // Reset with entries buffered.
    bus.out_ready = 1'b0;
    drive(tbl[0]);
    step();
    drive(tbl[1]);
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_reset_in_ready", 128'(bus.in_ready), 128'(1'b0));
    step();
    chk("mid_reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("mid_reset_payload", 128'(act), 128'(0));
    chk("mid_reset_in_ready_held", 128'(bus.in_ready), 128'(1'b0));
    sb.delete();
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    bus.out_ready = 1'b1;
    drive(tbl[4]);
    step();
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
